// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential radix-2 restoring divider.
// State encodings and a constant-function log2 used to size the bit counter.
package seq_div_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Relies on i_rem < i_dvs, so the VW-bit difference is exact whenever the subtraction succeeds.
module seq_div_step #(
  parameter int unsigned VW = 8
) (
  input  logic [VW-1:0] i_rem,
  input  logic          i_bit,
  input  logic [VW-1:0] i_dvs,
  output logic [VW-1:0] o_rem,
  output logic          o_q
);

  logic [VW:0]   w_s;
  logic [VW-1:0] w_diff;

  always_comb begin
    w_s    = {i_rem, i_bit};
    w_diff = w_s[VW-1:0] - i_dvs;
    o_q    = (w_s >= {1'b0, i_dvs});
    o_rem  = o_q ? w_diff : w_s[VW-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, start/busy/valid handshake.
// Optional two's-complement mode (signed_op port) when SEQ_DIV_SIGNED_EN is defined.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic          signed_op,
`endif
  output logic          busy,
  output logic          valid,
  output logic          dbz,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);

  localparam int unsigned CW = clog2(DW);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dvd;
  logic [VW-1:0] r_dvs;
  logic [VW-1:0] r_rem;
  logic [DW-1:0] r_quo;
  logic [VW-1:0] r_rem_o;
  logic          r_busy;
  logic          r_valid;
  logic          r_dbz;

  logic [DW-1:0] w_dvd_mag;
  logic [VW-1:0] w_dvs_mag;
  logic [DW-1:0] w_q_next;
  logic [VW-1:0] w_rem_next;
  logic          w_q_bit;
  logic [DW-1:0] w_quo_fix;
  logic [VW-1:0] w_rem_fix;

  seq_div_step #(.VW(VW)) u_step (
    .i_rem (r_rem),
    .i_bit (r_dvd[DW-1]),
    .i_dvs (r_dvs),
    .o_rem (w_rem_next),
    .o_q   (w_q_bit)
  );

  // r_dvd doubles as the quotient register: dividend bits leave at the top
  // while quotient bits enter at the bottom, so after DW steps it holds q.
  assign w_q_next = {r_dvd[DW-2:0], w_q_bit};

`ifdef SEQ_DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_dvd_neg;
  logic w_dvs_neg;

  always_comb begin
    w_dvd_neg = signed_op & dividend[DW-1];
    w_dvs_neg = signed_op & divisor[VW-1];
    w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    w_dvs_mag = w_dvs_neg ? -divisor : divisor;
    w_quo_fix = r_neg_q ? -w_q_next : w_q_next;
    w_rem_fix = r_neg_r ? -w_rem_next : w_rem_next;
  end
`else
  always_comb begin
    w_dvd_mag = dividend;
    w_dvs_mag = divisor;
    w_quo_fix = w_q_next;
    w_rem_fix = w_rem_next;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_rem_o <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_dbz   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (divisor == '0) begin
              r_state <= DONE;
              r_valid <= 1'b1;
              r_dbz   <= 1'b1;
              r_quo   <= '1;
              r_rem_o <= dividend[VW-1:0];
            end else begin
              r_state <= RUN;
              r_dbz   <= 1'b0;
              r_quo   <= '0;
              r_rem_o <= '0;
              r_cnt   <= CW'(DW - 1);
              r_dvd   <= w_dvd_mag;
              r_dvs   <= w_dvs_mag;
              r_rem   <= '0;
`ifdef SEQ_DIV_SIGNED_EN
              r_neg_q <= w_dvd_neg ^ w_dvs_neg;
              r_neg_r <= w_dvd_neg;
`endif
            end
          end
        end
        RUN: begin
          r_dvd <= w_q_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_quo   <= w_quo_fix;
            r_rem_o <= w_rem_fix;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          // busy stays high through the valid cycle and drops on the way back to IDLE
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign valid     = r_valid;
  assign dbz       = r_dbz;
  assign quotient  = r_quo;
  assign remainder = r_rem_o;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (DW=16, VW=8).
// Signed vectors are exercised only when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_divider;

  localparam int DW = 16;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
`ifdef SEQ_DIV_SIGNED_EN
  logic          signed_op = 1'b0;
`endif
  logic          busy;
  logic          valid;
  logic          dbz;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
`ifdef SEQ_DIV_SIGNED_EN
    .signed_op (signed_op),
`endif
    .busy      (busy),
    .valid     (valid),
    .dbz       (dbz),
    .quotient  (quotient),
    .remainder (remainder)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for valid; latency is counted in
  // falling-edge samples after the accepting rising edge.
  task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic ed,
                        input int elat);
    int   n;
    logic all_busy;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    n = 1;
    all_busy = 1'b1;
    while (!valid && n < 40) begin
      all_busy &= busy;
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(elat));
    chk({tag, ".busy_run"}, 32'(all_busy), 32'd1);
    chk({tag, ".busy_at_valid"}, 32'(busy), 32'd1);
    chk({tag, ".q"}, 32'(quotient), 32'(eq));
    chk({tag, ".r"}, 32'(remainder), 32'(er));
    chk({tag, ".dbz"}, 32'(dbz), 32'(ed));
    @(negedge clk);
    chk({tag, ".valid_pulse"}, 32'(valid), 32'd0);
    chk({tag, ".busy_after"}, 32'(busy), 32'd0);
    chk({tag, ".q_hold"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    int   n;
    logic seen_valid;
    logic seen_busy;

    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.valid", 32'(valid), 32'd0);
    chk("reset.dbz", 32'(dbz), 32'd0);
    chk("reset.q", 32'(quotient), 32'd0);
    chk("reset.r", 32'(remainder), 32'd0);
    rst = 1'b1;

    run_op("100/7", 16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 17);
    run_op("5/9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 17);
    run_op("65535/255", 16'hFFFF, 8'd255, 16'd257, 8'd0, 1'b0, 17);
    run_op("65535/1", 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, 17);
    run_op("1234/0", 16'd1234, 8'd0, 16'hFFFF, 8'hD2, 1'b1, 1);
    run_op("21/7", 16'd21, 8'd7, 16'd3, 8'd0, 1'b0, 17);

    // start re-pulsed mid-run and during DONE must be ignored
    @(negedge clk);
    dividend = 16'd100; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = 16'd999; divisor = 8'd3;
    n = 1;
    repeat (4) begin @(negedge clk); n++; end
    start = 1'b1;
    @(negedge clk); n++;
    start = 1'b0;
    while (!valid && n < 40) begin @(negedge clk); n++; end
    chk("repulse.lat", 32'(n), 32'd17);
    chk("repulse.q", 32'(quotient), 32'd14);
    chk("repulse.r", 32'(remainder), 32'd2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse.busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("done_pulse.busy_later", 32'(busy), 32'd0);
    chk("done_pulse.q", 32'(quotient), 32'd14);
    chk("done_pulse.r", 32'(remainder), 32'd2);

    // start held high: re-accept lands two clocks after each valid
    @(negedge clk);
    dividend = 16'd100; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    n = 1;
    while (!valid && n < 40) begin @(negedge clk); n++; end
    chk("hold.lat1", 32'(n), 32'd17);
    @(negedge clk);
    chk("hold.gap_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("hold.reaccept_busy", 32'(busy), 32'd1);
    dividend = 16'd200; divisor = 8'd3;
    n = 1;
    while (!valid && n < 40) begin @(negedge clk); n++; end
    start = 1'b0;
    chk("hold.lat2", 32'(n), 32'd17);
    chk("hold.q2", 32'(quotient), 32'd14);
    chk("hold.r2", 32'(remainder), 32'd2);
    repeat (2) @(negedge clk);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    dividend = 16'd200; divisor = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort.busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.valid", 32'(valid), 32'd0);
    chk("abort.q", 32'(quotient), 32'd0);
    chk("abort.r", 32'(remainder), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 1'b0;
    seen_busy  = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen_valid |= valid;
      seen_busy  |= busy;
    end
    chk("abort.no_valid", 32'(seen_valid), 32'd0);
    chk("abort.no_busy", 32'(seen_busy), 32'd0);
    run_op("200/3", 16'd200, 8'd3, 16'd66, 8'd2, 1'b0, 17);

`ifdef SEQ_DIV_SIGNED_EN
    signed_op = 1'b1;
    run_op("s-100/7", 16'hFF9C, 8'd7, 16'hFFF2, 8'hFE, 1'b0, 17);
    run_op("s100/-7", 16'd100, 8'hF9, 16'hFFF2, 8'h02, 1'b0, 17);
    run_op("s-32768/-1", 16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0, 17);
    run_op("s1234/0", 16'd1234, 8'd0, 16'hFFFF, 8'hD2, 1'b1, 1);
    signed_op = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "time limit");
  end

endmodule
